// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//
// Iterative unsigned multiply / restoring divide sequencer. It borrows the
// shared, registered ALU for every add or subtract and does all shifting
// locally. Each of the dw steps takes two cycles: ISSUE drives the ALU
// operands, and CAPTURE consumes the registered result.
//
// Optional feature: define ALU_MULDIV_DIVIDE_EN to build the divide path.
// Without it, fn is ignored, every request multiplies, div_zero is tied low,
// and the subtract op is never issued.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   RDY              global advance enable (forwarded as alu_rdy)
//   start, fn        request (sampled in IDLE), 0 = multiply / 1 = divide
//   opa, opb         operands, sampled when start is accepted
//   busy, done       operation in progress, one-cycle completion pulse
//   res_hi, res_lo   product high/low, or remainder/quotient
//   div_zero         last divide had a zero divisor
//   alu_*            ALU initiator interface (alu_out/alu_co come back)
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
   parameter int dw = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          RDY,
   input  logic          start,
   input  logic          fn,
   input  logic [dw-1:0] opa,
   input  logic [dw-1:0] opb,
   output logic          busy,
   output logic          done,
   output logic [dw-1:0] res_hi,
   output logic [dw-1:0] res_lo,
   output logic          div_zero,
   output logic [3:0]    alu_op,
   output logic          alu_right,
   output logic          alu_rotate,
   output logic [dw-1:0] alu_ai,
   output logic [dw-1:0] alu_bi,
   output logic          alu_ci,
   output logic [3:0]    alu_ei,
   output logic          alu_rdy,
   input  logic [dw-1:0] alu_out,
   input  logic          alu_co
);

   localparam int CW = $clog2(dw) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

   state_t        state_q;
   logic [dw-1:0] hi_q, lo_q, m_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q, done_q;
   logic [dw-1:0] res_hi_q, res_lo_q;
   logic [3:0]    alu_op_q;
   logic [dw-1:0] alu_ai_q, alu_bi_q;
   logic          alu_ci_q;

   // Values the partial-result registers take after a CAPTURE edge.
   logic [dw-1:0] cap_hi, cap_lo;
   // Register contents on entry to ISSUE, and the ALU drive they imply.
   // The ALU outputs are registered, so they are computed one edge early.
   logic [dw-1:0] iss_hi, iss_lo, iss_m;
   logic [3:0]    iss_op;
   logic [dw-1:0] iss_ai, iss_bi;
   logic          iss_ci;

`ifdef ALU_MULDIV_DIVIDE_EN
   logic          mode_q;
   logic          div_zero_q;
   logic [dw:0]   hold_q;      // {ov, s} kept from ISSUE for use in CAPTURE
   logic          iss_mode;
   logic [dw:0]   iss_hold;
   logic          ok;
`else
   logic          unused_fn;
   assign unused_fn = fn;
`endif

   always_comb begin
      cap_hi = {alu_co, alu_out[dw-1:1]};
      cap_lo = {alu_out[0], lo_q[dw-1:1]};
`ifdef ALU_MULDIV_DIVIDE_EN
      // A set ov bit means the shifted remainder already exceeds the divisor.
      ok = alu_co | hold_q[dw];
      if (mode_q) begin
         cap_hi = ok ? alu_out : hold_q[dw-1:0];
         cap_lo = {lo_q[dw-2:0], ok};
      end
`endif
   end

   always_comb begin
      if (state_q == S_IDLE) begin
         iss_hi = '0;
`ifdef ALU_MULDIV_DIVIDE_EN
         iss_mode = fn;
         iss_lo   = fn ? opa : opb;   // multiply walks the multiplier in lo
         iss_m    = fn ? opb : opa;
`else
         iss_lo = opb;
         iss_m  = opa;
`endif
      end else begin
         iss_hi = cap_hi;
         iss_lo = cap_lo;
         iss_m  = m_q;
`ifdef ALU_MULDIV_DIVIDE_EN
         iss_mode = mode_q;
`endif
      end
      iss_op = 4'b0011;
      iss_ai = iss_hi;
      iss_bi = iss_lo[0] ? iss_m : '0;
      iss_ci = 1'b0;
`ifdef ALU_MULDIV_DIVIDE_EN
      iss_hold = {iss_hi, iss_lo[dw-1]};
      if (iss_mode) begin
         // s - m as s + ~m + 1; carry out means no borrow.
         iss_op = 4'b0111;
         iss_ai = iss_hold[dw-1:0];
         iss_bi = iss_m;
         iss_ci = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         res_hi_q <= '0;
         res_lo_q <= '0;
         alu_op_q <= 4'b1111;
         alu_ai_q <= '0;
         alu_bi_q <= '0;
         alu_ci_q <= 1'b0;
`ifdef ALU_MULDIV_DIVIDE_EN
         mode_q     <= 1'b0;
         div_zero_q <= 1'b0;
         hold_q     <= '0;
`endif
      end else if (RDY) begin
         // Idle drive unless the next state is ISSUE.
         alu_op_q <= 4'b1111;
         alu_ai_q <= '0;
         alu_bi_q <= '0;
         alu_ci_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  hi_q     <= iss_hi;
                  lo_q     <= iss_lo;
                  m_q      <= iss_m;
                  cnt_q    <= CW'(dw);
                  busy_q   <= 1'b1;
                  state_q  <= S_ISSUE;
                  alu_op_q <= iss_op;
                  alu_ai_q <= iss_ai;
                  alu_bi_q <= iss_bi;
                  alu_ci_q <= iss_ci;
`ifdef ALU_MULDIV_DIVIDE_EN
                  mode_q     <= iss_mode;
                  hold_q     <= iss_hold;
                  div_zero_q <= fn && (opb == '0);
`endif
               end
            end
            S_ISSUE: state_q <= S_CAPTURE;
            S_CAPTURE: begin
               hi_q  <= cap_hi;
               lo_q  <= cap_lo;
               cnt_q <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  res_hi_q <= cap_hi;
                  res_lo_q <= cap_lo;
               end else begin
                  state_q  <= S_ISSUE;
                  alu_op_q <= iss_op;
                  alu_ai_q <= iss_ai;
                  alu_bi_q <= iss_bi;
                  alu_ci_q <= iss_ci;
`ifdef ALU_MULDIV_DIVIDE_EN
                  hold_q <= iss_hold;
`endif
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign res_hi     = res_hi_q;
   assign res_lo     = res_lo_q;
`ifdef ALU_MULDIV_DIVIDE_EN
   assign div_zero   = div_zero_q;
`else
   assign div_zero   = 1'b0;
`endif
   assign alu_op     = alu_op_q;
   assign alu_right  = 1'b0;
   assign alu_rotate = 1'b0;
   assign alu_ai     = alu_ai_q;
   assign alu_bi     = alu_bi_q;
   assign alu_ci     = alu_ci_q;
   assign alu_ei     = 4'd0;
   assign alu_rdy    = RDY;

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Iterative multiply/divide sequencer that drives the shared `ALU` as its initiator. It turns one `start` request into a sequence of ALU add/subtract operations and shifts the partial result locally. It delivers a 2·dw-bit unsigned product, or a dw-bit quotient and remainder. It sits beside the core's datapath and borrows the ALU while the core is stalled on it.

## Interface
- `dw`, 16, data width; must match the connected ALU (8 for 6502, 16 for 65Org16).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `RDY`  in  1  global advance enable; when low, all state holds. Forwarded to the ALU as `alu_rdy`.
- `start`  in  1  request; sampled only in IDLE.
- `fn`  in  1  0 = multiply, 1 = divide (see Configuration).
- `opa`  in  dw  multiplicand or dividend; sampled when `start` is accepted.
- `opb`  in  dw  multiplier or divisor; sampled when `start` is accepted.
- `busy`  out  1  operation in progress.
- `done`  out  1  single-cycle pulse; the result is valid from this cycle on.
- `res_hi`  out  dw  product high half, or remainder.
- `res_lo`  out  dw  product low half, or quotient.
- `div_zero`  out  1  last divide had `opb`==0.
- `alu_op`  out  4  ALU op code.
- `alu_right`, `alu_rotate`  out  1 each  ALU shift controls.
- `alu_ai`, `alu_bi`  out  dw each  ALU operands.
- `alu_ci`  out  1  ALU carry in.
- `alu_ei`  out  4  ALU shift amount.
- `alu_rdy`  out  1  ALU advance enable; equals `RDY`.
- `alu_out`  in  dw  registered ALU result.
- `alu_co`  in  1  registered ALU carry out.

## Operation
- Registers: `hi`, `lo`, `m` (dw each), `cnt` (log2(dw)+1 bits), `mode`, FSM.
- `alu_right`, `alu_rotate` and `alu_ei` are always 0, so the ALU shifter is never used. All shifting happens locally.
- IDLE
  - Outputs: `alu_op`=4'b1111, `alu_ai`=0, `alu_bi`=0, `alu_ci`=0.
  - On `start`&`RDY`: load `hi`=0, `lo`=`opa`, `m`=`opb`, `cnt`=dw, `mode`=`fn`.
  - Multiply swaps the operands: `lo`=`opb`, `m`=`opa`.
  - Clear `div_zero` (divide sets it to (`opb`==0)). Set `busy`=1 and go to ISSUE.
- ISSUE, multiply
  - Drive `alu_op`=4'b0011, `alu_ai`=`hi`, `alu_bi`=`lo[0]` ? `m` : 0, `alu_ci`=0.
  - Go to CAPTURE.
- ISSUE, divide
  - Let s = {`hi`[dw-2:0], `lo`[dw-1]} (remainder shifted left) and ov = `hi`[dw-1].
  - Drive `alu_op`=4'b0111, `alu_ai`=s, `alu_bi`=`m`, `alu_ci`=1.
  - Go to CAPTURE.
- CAPTURE, multiply
  - `hi` = {`alu_co`, `alu_out`[dw-1:1]}, `lo` = {`alu_out`[0], `lo`[dw-1:1]}.
- CAPTURE, divide
  - ok = `alu_co` | ov.
  - `hi` = ok ? `alu_out` : s; `lo` = {`lo`[dw-2:0], ok}.
  - Keep s and ov in a holding register across ISSUE→CAPTURE.
- CAPTURE, both modes
  - Decrement `cnt`. If `cnt` was 1, go to DONE; otherwise go to ISSUE.
- DONE
  - `done`=1 and `busy`=0; `res_hi`/`res_lo` are updated from `hi`/`lo`.
  - Go to IDLE.
- Results hold until the next DONE.
- Arithmetic is unsigned. Any carry beyond dw bits in multiply is captured through `alu_co`, so no overflow is possible.
- Divide by zero falls out of the algorithm naturally:
  - quotient = all ones, remainder = dividend, `div_zero`=1.
- `start` while busy is ignored, with no queueing. `start` in the DONE cycle is also ignored.

## Timing
- Reset values: `busy`=0, `done`=0, `res_hi`=0, `res_lo`=0, `div_zero`=0, FSM=IDLE, `alu_op`=4'b1111, all other `alu_*` outputs 0.
- Every state transition and register update requires `RDY`=1. With `RDY`=0 the FSM and outputs hold, and the ALU freezes too.
- The ALU result is registered: operands driven in ISSUE cycle k appear on `alu_out`/`alu_co` in cycle k+1 (CAPTURE).
- Latency: with `start` accepted at edge 0, there are 2·dw ISSUE/CAPTURE cycles and `done` is high during cycle 2·dw+1.
  - dw=16: 33 cycles. dw=8: 17 cycles. Each `RDY`-low cycle adds one.
- Reset mid-operation: return to IDLE next edge with the reset values above. Reset wins over a simultaneous `start`.
- Stale ALU contents are never consumed: every CAPTURE is preceded by its own ISSUE.

## Configuration
- Macro `ALU_MULDIV_DIVIDE_EN`.
- Defined: `fn`=1 selects restoring divide as above.
- Undefined: the divide path is not built.
  - `fn` is ignored and every request multiplies.
  - `div_zero` is tied to 0.
  - The subtract op (4'b0111) is never issued.

## Test plan
- Multiply, dw=16: `opa`=0x1234, `opb`=0x5678 → `done` exactly 33 cycles after the start edge; `res_hi`=0x0626, `res_lo`=0x0060.
- Multiply extremes: 0xFFFF×0xFFFF → `res_hi`=0xFFFE, `res_lo`=0x0001. 0×0xABCD → 0x0000/0x0000.
- Divide (macro on): 0xFFFF÷0x0010 → `res_lo`=0x0FFF, `res_hi`=0x000F, `div_zero`=0. Also 0x8001÷0x8000 → `res_lo`=1, `res_hi`=1 (exercises the ov path).
- Divide by zero: 0x1234÷0 → `res_lo`=0xFFFF, `res_hi`=0x1234, `div_zero`=1. With the macro off, the same request returns product 0.
- Stall and abort:
  - Hold `RDY`=0 for 5 cycles mid-multiply → `done` at cycle 38 and the result is unchanged.
  - `start` while busy → ignored.
  - `reset` at cycle 10 → `busy`=0, results 0 next cycle; a fresh `start` then completes correctly.
